fsm_ring_sequencer: RTL and testbench

//   Parametrised ring state sequencer: NUM_STATES states S0..S(N-1), stepped in a ring.

---
 rtl/fsm_ring_sequencer.sv | 133 +++++++++++++
 tb/tb_fsm_ring_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ring_sequencer.sv
// Ring state sequencer over NUM_STATES states with a selectable register encoding,
// per-state dwell, direction control, parallel load, wrap pulse and illegal-state recovery.
module fsm_ring_sequencer #(
  parameter int    NUM_STATES = 3,
  parameter string ENCODING   = "ONEHOT",
  parameter int    DWELL      = 1,
  parameter int    IDX_W      = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [IDX_W-1:0]      load_idx,
  output logic [IDX_W-1:0]      state_idx,
  output logic [NUM_STATES-1:0] state_onehot,
  output logic                  q,
  output logic                  wrap,
  output logic                  err
);

  localparam bit IS_ONEHOT = (ENCODING == "ONEHOT");
  localparam bit IS_GRAY   = (ENCODING == "GRAY");
  localparam int REG_W     = IS_ONEHOT ? NUM_STATES : IDX_W;
  localparam int CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam bit TWO_RING  = (NUM_STATES == 2);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STATES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [REG_W-1:0] state_r, state_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic             wrap_r, wrap_nxt;
  logic             err_r, err_nxt;
  logic [IDX_W-1:0] cur_idx, step_idx;
  logic             step_wrap, illegal, load_ok;

  function automatic logic [IDX_W-1:0] gray2bin(input logic [IDX_W-1:0] g);
    logic [IDX_W-1:0] b;
    b[IDX_W-1] = g[IDX_W-1];
    for (int i = IDX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [REG_W-1:0] encode(input logic [IDX_W-1:0] idx);
    if (IS_ONEHOT)    return REG_W'(1) << idx;
    else if (IS_GRAY) return REG_W'(idx ^ (idx >> 1));
    else              return REG_W'(idx);
  endfunction

  // Decode the register back to an index and flag codes that name no ring state.
  generate
    if (IS_ONEHOT) begin : g_dec_onehot
      logic [6:0] ones;
      always_comb begin
        cur_idx = '0;
        ones    = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
          if (state_r[i]) begin
            cur_idx = IDX_W'(i);
            ones    = ones + 7'd1;
          end
        end
      end
      assign illegal = (ones != 7'd1);
    end else begin : g_dec_index
      assign cur_idx = IS_GRAY ? gray2bin(state_r) : state_r;
      assign illegal = (32'(cur_idx) >= NUM_STATES);
    end
  endgenerate

  // With two states both directions land on the other state, so every step wraps.
  always_comb begin
    if (dir) begin
      step_idx  = (cur_idx == '0) ? LAST_IDX : cur_idx - IDX_W'(1);
      step_wrap = TWO_RING || (cur_idx == '0);
    end else begin
      step_idx  = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
      step_wrap = TWO_RING || (cur_idx == LAST_IDX);
    end
  end

  assign load_ok = (32'(load_idx) < NUM_STATES);

  always_comb begin
    state_nxt = state_r;
    dwell_nxt = dwell_cnt;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      dwell_nxt = '0;
      if (load_ok) begin
        state_nxt = encode(load_idx);
      end else begin
        state_nxt = encode('0);
        err_nxt   = 1'b1;
      end
    end else if (illegal) begin
      state_nxt = encode('0);
      dwell_nxt = '0;
      err_nxt   = 1'b1;
    end else if (en) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_nxt = '0;
        state_nxt = encode(step_idx);
        wrap_nxt  = step_wrap;
      end else begin
        dwell_nxt = dwell_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= encode('0);
      dwell_cnt <= '0;
      wrap_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      dwell_cnt <= dwell_nxt;
      wrap_r    <= wrap_nxt;
      err_r     <= err_nxt;
    end
  end

  assign state_idx    = cur_idx;
  assign state_onehot = NUM_STATES'(1) << cur_idx;
  assign q            = state_onehot[0];
  assign wrap         = wrap_r;
  assign err          = err_r;

endmodule

// File: tb/tb_fsm_ring_sequencer.sv
// Directed-vector and model-compared bench for fsm_ring_sequencer across encodings,
// dwell lengths, ring sizes, load, wrap and illegal-state recovery.
module tb_fsm_ring_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] ld = 3'd0;

  logic [1:0] idx_a, idx_d;
  logic [2:0] idx_b, idx_c, idx_e, idx_f, idx_g;
  logic [0:0] idx_h;
  logic [2:0] oh_a, oh_d;
  logic [4:0] oh_b, oh_e, oh_f, oh_g;
  logic [5:0] oh_c;
  logic [1:0] oh_h;
  logic q_a, q_b, q_c, q_d, q_e, q_f, q_g, q_h;
  logic w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic e_a, e_b, e_c, e_d, e_e, e_f, e_g, e_h;

  fsm_ring_sequencer #(.NUM_STATES(3), .ENCODING("ONEHOT"), .DWELL(1)) dut_a (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld[1:0]),
    .state_idx(idx_a), .state_onehot(oh_a), .q(q_a), .wrap(w_a), .err(e_a));
  fsm_ring_sequencer #(.NUM_STATES(5), .ENCODING("BINARY"), .DWELL(3)) dut_b (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld),
    .state_idx(idx_b), .state_onehot(oh_b), .q(q_b), .wrap(w_b), .err(e_b));
  fsm_ring_sequencer #(.NUM_STATES(6), .ENCODING("GRAY"), .DWELL(2)) dut_c (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld),
    .state_idx(idx_c), .state_onehot(oh_c), .q(q_c), .wrap(w_c), .err(e_c));
  fsm_ring_sequencer #(.NUM_STATES(3), .ENCODING("BINARY"), .DWELL(1)) dut_d (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld[1:0]),
    .state_idx(idx_d), .state_onehot(oh_d), .q(q_d), .wrap(w_d), .err(e_d));
  fsm_ring_sequencer #(.NUM_STATES(2), .ENCODING("ONEHOT"), .DWELL(1)) dut_h (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld[0:0]),
    .state_idx(idx_h), .state_onehot(oh_h), .q(q_h), .wrap(w_h), .err(e_h));
  fsm_ring_sequencer #(.NUM_STATES(5), .ENCODING("ONEHOT"), .DWELL(2)) dut_e (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld),
    .state_idx(idx_e), .state_onehot(oh_e), .q(q_e), .wrap(w_e), .err(e_e));
  fsm_ring_sequencer #(.NUM_STATES(5), .ENCODING("BINARY"), .DWELL(2)) dut_f (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld),
    .state_idx(idx_f), .state_onehot(oh_f), .q(q_f), .wrap(w_f), .err(e_f));
  fsm_ring_sequencer #(.NUM_STATES(5), .ENCODING("GRAY"), .DWELL(2)) dut_g (
    .clk(clk), .reset(rst), .en(en), .dir(dir), .load(load), .load_idx(ld),
    .state_idx(idx_g), .state_onehot(oh_g), .q(q_g), .wrap(w_g), .err(e_g));

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         sel;
    logic       r, e, d, l;
    logic [2:0] ldv;
    logic [2:0] idx;
    logic       w, er;
  } vec_t;
  vec_t vt[$];

  task automatic v(input int sel, input logic r, e, d, l, input logic [2:0] ldv,
                   input logic [2:0] idx, input logic w, er);
    vec_t t;
    t.sel = sel; t.r = r; t.e = e; t.d = d; t.l = l; t.ldv = ldv;
    t.idx = idx; t.w = w; t.er = er;
    vt.push_back(t);
  endtask

  task automatic get_out(input int sel, output logic [2:0] i, output logic [5:0] o,
                         output logic qq, output logic ww, output logic ee);
    case (sel)
      0: begin i = {1'b0, idx_a}; o = {3'b0, oh_a}; qq = q_a; ww = w_a; ee = e_a; end
      1: begin i = idx_b; o = {1'b0, oh_b}; qq = q_b; ww = w_b; ee = e_b; end
      2: begin i = idx_c; o = oh_c; qq = q_c; ww = w_c; ee = e_c; end
      3: begin i = {1'b0, idx_d}; o = {3'b0, oh_d}; qq = q_d; ww = w_d; ee = e_d; end
      4: begin i = {2'b0, idx_h}; o = {4'b0, oh_h}; qq = q_h; ww = w_h; ee = e_h; end
      5: begin i = idx_e; o = {1'b0, oh_e}; qq = q_e; ww = w_e; ee = e_e; end
      6: begin i = idx_f; o = {1'b0, oh_f}; qq = q_f; ww = w_f; ee = e_f; end
      default: begin i = idx_g; o = {1'b0, oh_g}; qq = q_g; ww = w_g; ee = e_g; end
    endcase
  endtask

  task automatic check(input string name, input int sel, input logic [2:0] ei,
                       input logic ew, input logic ee);
    logic [2:0] ai;
    logic [5:0] ao, eo;
    logic       aq, aw, ae, eq;
    get_out(sel, ai, ao, aq, aw, ae);
    eo = 6'd1 << ei;
    eq = (ei == 3'd0);
    checks++;
    if ({ai, ao, aq, aw, ae} === {ei, eo, eq, ew, ee}) passes++;
    else $display("FAIL %s dut%0d: got idx=%0d oh=%b q=%b wrap=%b err=%b, want idx=%0d oh=%b q=%b wrap=%b err=%b",
                  name, sel, ai, ao, aq, aw, ae, ei, eo, eq, ew, ee);
  endtask

  int         m_idx, m_cnt;
  logic       m_w, m_e;

  initial begin
    // N=3 one-hot, DWELL=1: forward ring, reverse wrap, load override, illegal load
    v(0,1,0,0,0,0, 0,0,0); v(0,1,0,0,0,0, 0,0,0);
    v(0,0,1,0,0,0, 1,0,0); v(0,0,1,0,0,0, 2,0,0); v(0,0,1,0,0,0, 0,1,0);
    v(0,0,1,0,0,0, 1,0,0); v(0,0,1,0,0,0, 2,0,0); v(0,0,1,0,0,0, 0,1,0);
    v(0,0,1,1,0,0, 2,1,0); v(0,0,1,1,0,0, 1,0,0); v(0,0,0,1,0,0, 1,0,0);
    v(0,0,1,0,1,0, 0,0,0); v(0,0,1,0,1,3, 0,0,1); v(0,0,1,0,0,0, 1,0,0);
    // N=5 binary, DWELL=3: reverse dwell, en freeze, dir mid-dwell, reset with load
    v(1,1,0,0,0,0, 0,0,0); v(1,1,0,0,0,0, 0,0,0);
    v(1,0,1,1,0,0, 0,0,0); v(1,0,1,1,0,0, 0,0,0); v(1,0,1,1,0,0, 4,1,0);
    v(1,0,1,1,0,0, 4,0,0); v(1,0,1,1,0,0, 4,0,0); v(1,0,1,1,0,0, 3,0,0);
    v(1,0,1,1,0,0, 3,0,0); v(1,0,1,1,0,0, 3,0,0); v(1,0,1,1,0,0, 2,0,0);
    v(1,0,1,1,0,0, 2,0,0); v(1,0,0,1,0,0, 2,0,0); v(1,0,0,0,0,0, 2,0,0);
    v(1,0,1,1,0,0, 2,0,0); v(1,0,1,1,0,0, 1,0,0);
    v(1,0,1,0,0,0, 1,0,0); v(1,0,1,1,0,0, 1,0,0); v(1,0,1,0,0,0, 2,0,0);
    v(1,0,1,0,0,0, 2,0,0); v(1,1,1,0,1,7, 0,0,0);
    v(1,0,1,1,0,0, 0,0,0); v(1,0,1,1,0,0, 0,0,0); v(1,0,1,1,0,0, 4,1,0);
    // N=6 gray, DWELL=2: load restarts dwell, illegal loads, both wraps
    v(2,1,0,0,0,0, 0,0,0);
    v(2,0,1,0,0,0, 0,0,0); v(2,0,1,0,0,0, 1,0,0); v(2,0,1,0,0,0, 1,0,0);
    v(2,0,1,0,1,4, 4,0,0); v(2,0,1,0,0,0, 4,0,0); v(2,0,1,0,0,0, 5,0,0);
    v(2,0,1,0,0,0, 5,0,0); v(2,0,1,0,0,0, 0,1,0);
    v(2,0,1,0,1,7, 0,0,1); v(2,0,1,0,0,0, 0,0,0); v(2,0,1,0,0,0, 1,0,0);
    v(2,0,0,0,1,5, 5,0,0); v(2,0,1,0,0,0, 5,0,0); v(2,0,1,0,0,0, 0,1,0);
    v(2,0,1,1,0,0, 0,0,0); v(2,0,1,1,0,0, 5,1,0);
    v(2,0,0,0,1,6, 0,0,1); v(2,0,0,0,0,0, 0,0,0);
    // N=3 binary, DWELL=1
    v(3,1,0,0,0,0, 0,0,0); v(3,0,1,1,0,0, 2,1,0); v(3,0,1,0,1,3, 0,0,1);
    // N=2: every step wraps in either direction
    v(4,1,0,0,0,0, 0,0,0); v(4,0,1,0,0,0, 1,1,0); v(4,0,1,1,0,0, 0,1,0);
    v(4,0,1,1,0,0, 1,1,0); v(4,0,0,0,0,0, 1,0,0); v(4,0,0,0,1,0, 0,0,0);

    foreach (vt[k]) begin
      @(negedge clk);
      rst = vt[k].r; en = vt[k].e; dir = vt[k].d; load = vt[k].l; ld = vt[k].ldv;
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), vt[k].sel, vt[k].idx, vt[k].w, vt[k].er);
    end

    // Illegal register contents recover to S0 with an err pulse, even with en high
    @(negedge clk); rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; ld = 3'd0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; en = 1'b1;
    force dut_a.state_r = 3'b011;
    force dut_d.state_r = 2'd3;
    #1;
    release dut_a.state_r;
    release dut_d.state_r;
    @(posedge clk); #1;
    check("illegal_onehot", 0, 3'd0, 1'b0, 1'b1);
    check("illegal_binary", 3, 3'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("recover_onehot", 0, 3'd1, 1'b0, 1'b0);
    check("recover_binary", 3, 3'd1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    force dut_a.state_r = 3'b011;
    force dut_d.state_r = 2'd3;
    #1;
    release dut_a.state_r;
    release dut_d.state_r;
    @(posedge clk); #1;
    check("illegal_reset_onehot", 0, 3'd0, 1'b0, 1'b0);
    check("illegal_reset_binary", 3, 3'd0, 1'b0, 1'b0);

    // Random traffic: all three encodings against one reference model
    m_idx = 0; m_cnt = 0; m_w = 1'b0; m_e = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rst  = (k == 0) || ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      ld   = 3'($urandom_range(0, 7));
      if (rst) begin
        m_idx = 0; m_cnt = 0; m_w = 1'b0; m_e = 1'b0;
      end else if (load) begin
        m_cnt = 0; m_w = 1'b0;
        if (int'(ld) < 5) begin m_idx = int'(ld); m_e = 1'b0; end
        else begin m_idx = 0; m_e = 1'b1; end
      end else begin
        m_w = 1'b0; m_e = 1'b0;
        if (en) begin
          if (m_cnt == 1) begin
            m_cnt = 0;
            if (dir) begin m_w = (m_idx == 0); m_idx = (m_idx + 4) % 5; end
            else     begin m_w = (m_idx == 4); m_idx = (m_idx + 1) % 5; end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      @(posedge clk); #1;
      check($sformatf("rand%0d_onehot", k), 5, 3'(m_idx), m_w, m_e);
      check($sformatf("rand%0d_binary", k), 6, 3'(m_idx), m_w, m_e);
      check($sformatf("rand%0d_gray", k), 7, 3'(m_idx), m_w, m_e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
